// File: rtl/operand_bypass_unit_pkg.sv
// rtl/operand_bypass_unit_pkg.sv - shared widths, tracker entry type and helpers for the operand bypass unit
// Contents: REG_ADDR_W, T_W, REG_ZERO, entry_t {valid, dst, tnew}, sel_w(), tnew_dec()
package bypass_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int T_W        = 2;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic [T_W-1:0]        tnew;
    } entry_t;

    // Width of a per-operand select: 0 = register file, k+1 = stage k.
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

endpackage

// File: rtl/operand_bypass_unit_if.sv
// rtl/operand_bypass_unit_if.sv - decode/bypass handshake bundle with master (decode) and slave (bypass unit) modports
// Signals: flush, d_valid, d_dst, d_tnew, d_src, d_tuse, d_rf_data, stg_data -> bypass unit
//          fwd_data, fwd_sel, stall <- bypass unit
interface operand_bypass_unit_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int T_W        = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
);

    logic                          flush;
    logic                          d_valid;
    logic [REG_ADDR_W-1:0]         d_dst;
    logic [T_W-1:0]                d_tnew;
    logic [NUM_SRC*REG_ADDR_W-1:0] d_src;
    logic [NUM_SRC*T_W-1:0]        d_tuse;
    logic [NUM_SRC*DATA_W-1:0]     d_rf_data;
    logic [DEPTH*DATA_W-1:0]       stg_data;
    logic [NUM_SRC*DATA_W-1:0]     fwd_data;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          stall;

    modport master (
        output flush, d_valid, d_dst, d_tnew, d_src, d_tuse, d_rf_data, stg_data,
        input  fwd_data, fwd_sel, stall
    );

    modport slave (
        input  flush, d_valid, d_dst, d_tnew, d_src, d_tuse, d_rf_data, stg_data,
        output fwd_data, fwd_sel, stall
    );

endinterface

// File: rtl/operand_bypass_unit_entry.sv
// rtl/operand_bypass_unit_entry.sv - one tracked pipeline stage: load/shift, saturating tnew decrement, clear
// Ports: clk, reset (async, active-high), clear (flush), entry_in (from decode or younger stage), entry_q (held entry)
module bypass_entry
    import bypass_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   clear,
    input  entry_t entry_in,
    output entry_t entry_q
);

    entry_t entry_d;

    // The countdown is applied as the entry moves in, so an entry sitting in a
    // stage always shows the cycles still needed from that stage onward.
    always_comb begin
        entry_d = '0;
        if (!clear && entry_in.valid) begin
            entry_d.valid = 1'b1;
            entry_d.dst   = entry_in.dst;
            entry_d.tnew  = tnew_dec(entry_in.tnew);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/operand_bypass_unit.sv
// rtl/operand_bypass_unit.sv - in-order pipeline bypass/hazard unit: writer tracker, priority forwarding, stall
// Ports: clk, reset (async, active-high), bus (operand_bypass_unit_if.slave),
//        stall_cnt [31:0] only when BYPASS_PERF_EN is defined (saturating stall-cycle count)
// Register-address and tnew/tuse widths come from bypass_pkg because the entry struct is shared.
module operand_bypass_unit
    import bypass_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
) (
    input  logic clk,
    input  logic reset,
    operand_bypass_unit_if.slave bus
`ifdef BYPASS_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int SEL_W = sel_w(DEPTH);

    entry_t stage_in [DEPTH];
    entry_t stage_q  [DEPTH];
    entry_t head_entry;

    logic                      stall_raw;
    logic                      stall;
    logic                      load;
    logic [NUM_SRC*DATA_W-1:0] fwd_data_c;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_c;

    // Flush overrides any hazard: the stalled consumer is being discarded anyway.
    assign stall = stall_raw & ~bus.flush;
    assign load  = bus.d_valid & ~stall & ~bus.flush & (bus.d_dst != REG_ZERO);

    always_comb begin
        head_entry = '0;
        if (load) begin
            head_entry.valid = 1'b1;
            head_entry.dst   = bus.d_dst;
            head_entry.tnew  = bus.d_tnew;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stage_in[g] = head_entry;
        end else begin : g_tail
            assign stage_in[g] = stage_q[g-1];
        end

        bypass_entry u_entry (
            .clk      (clk),
            .reset    (reset),
            .clear    (bus.flush),
            .entry_in (stage_in[g]),
            .entry_q  (stage_q[g])
        );
    end

    // Per operand, scan oldest to youngest so the youngest match is the one left
    // standing; older writers to the same register are hidden (WAW in flight).
    always_comb begin
        logic [REG_ADDR_W-1:0] src;
        logic [T_W-1:0]        tuse;
        logic                  hit;
        int                    hit_k;
        logic [T_W-1:0]        hit_tnew;

        stall_raw  = 1'b0;
        fwd_data_c = '0;
        fwd_sel_c  = '0;

        for (int i = 0; i < NUM_SRC; i++) begin
            src      = bus.d_src[i*REG_ADDR_W +: REG_ADDR_W];
            tuse     = bus.d_tuse[i*T_W +: T_W];
            hit      = 1'b0;
            hit_k    = 0;
            hit_tnew = '0;

            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (stage_q[k].valid && stage_q[k].dst == src) begin
                    hit      = 1'b1;
                    hit_k    = k;
                    hit_tnew = stage_q[k].tnew;
                end
            end

            if (src == REG_ZERO) begin
                fwd_data_c[i*DATA_W +: DATA_W] = '0;
                fwd_sel_c[i*SEL_W +: SEL_W]    = '0;
            end else if (hit && hit_tnew == '0) begin
                fwd_data_c[i*DATA_W +: DATA_W] = bus.stg_data[hit_k*DATA_W +: DATA_W];
                fwd_sel_c[i*SEL_W +: SEL_W]    = SEL_W'(hit_k + 1);
            end else begin
                // No writer, or the youngest writer is not ready yet: the RF value
                // is presented, and stall below covers the case where it matters.
                fwd_data_c[i*DATA_W +: DATA_W] = bus.d_rf_data[i*DATA_W +: DATA_W];
                fwd_sel_c[i*SEL_W +: SEL_W]    = '0;
            end

            if (src != REG_ZERO && hit && hit_tnew > tuse) begin
                stall_raw = 1'b1;
            end
        end
    end

    assign bus.fwd_data = fwd_data_c;
    assign bus.fwd_sel  = fwd_sel_c;
    assign bus.stall    = stall;

`ifdef BYPASS_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
